// File: rtl/delay_meter_pkg.sv
// ============================================================================
// Module : delay_meter_pkg
// Brief  : Shared types, defaults and width helper for the delay meter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package delay_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_FIRE    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int DEF_CNT_W        = 8;
  localparam int DEF_SAMPLES_LOG2 = 2;

  // Accumulator width that holds 2**samples_log2 full-scale sample counts.
  function automatic int sum_width(input int cnt_w, input int samples_log2);
    return cnt_w + samples_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/delay_meter_bit_sync.sv
// ============================================================================
// Module : bit_sync
// Brief  : Multi-flop synchroniser for one asynchronous bit, reset to RESET_VAL.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/delay_meter.sv
// ============================================================================
// Module : delay_meter
// Brief  : Launch/capture controller measuring the inverter delay path in clk
//          cycles; accumulates sum, min and max over 2**SAMPLES_LOG2 samples.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int TIMEOUT      = 255,
  parameter int SAMPLES_LOG2 = DEF_SAMPLES_LOG2,
  parameter int SETTLE_CYC   = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int INVERT       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          sense_i,
  output logic                          launch_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic [CNT_W+SAMPLES_LOG2-1:0] sum_o,
  output logic [CNT_W-1:0]              min_o,
  output logic [CNT_W-1:0]              max_o
);

  localparam int   SUM_W  = sum_width(CNT_W, SAMPLES_LOG2);
  localparam int   SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic c_act  = (INVERT != 0) ? 1'b0 : 1'b1;
  localparam logic c_rest = ~c_act;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_launch;
  logic                    w_launch_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [SET_W-1:0]        r_settle;
  logic [SAMPLES_LOG2-1:0] r_idx;
  logic [SUM_W-1:0]        r_sum;
  logic [CNT_W-1:0]        r_min;
  logic [CNT_W-1:0]        r_max;
  logic                    r_timeout;

  logic w_sense_s;
  logic w_hit;
  logic w_expired;
  logic w_settled;
  logic w_last;

  bit_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (c_rest)
  ) u_sense_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sense_i),
    .q_o (w_sense_s)
  );

  assign w_hit     = (w_sense_s == c_act);
  assign w_expired = (r_cnt == CNT_W'(TIMEOUT));
  assign w_settled = (r_settle == SET_W'(SETTLE_CYC - 1));
  assign w_last    = &r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_launch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_launch <= w_launch_nxt;
    end
  end

  // launch_o is registered: it is high exactly while the FSM sits in WAIT.
  always_comb begin
    w_state_nxt  = r_state;
    w_launch_nxt = 1'b0;
    case (r_state)
      ST_IDLE:    if (start_i) w_state_nxt = ST_SETTLE;
      ST_SETTLE:  if (w_settled) w_state_nxt = ST_FIRE;
      ST_FIRE: begin
        w_state_nxt  = ST_WAIT;
        w_launch_nxt = 1'b1;
      end
      ST_WAIT: begin
        if (w_hit) begin
          w_state_nxt = ST_CAPTURE;
        end else if (w_expired) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_launch_nxt = 1'b1;
        end
      end
      ST_CAPTURE: w_state_nxt = w_last ? ST_DONE : ST_SETTLE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_settle  <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_min     <= '1;
      r_max     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_settle  <= '0;
            r_idx     <= '0;
            r_sum     <= '0;
            r_min     <= '1;
            r_max     <= '0;
            r_timeout <= 1'b0;
          end
        end
        ST_SETTLE: r_settle <= w_settled ? '0 : r_settle + 1'b1;
        ST_FIRE:   r_cnt <= '0;
        ST_WAIT: begin
          if (!w_hit) begin
            if (w_expired) begin
              r_timeout <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          r_sum <= r_sum + SUM_W'(r_cnt);
          if (r_cnt < r_min) r_min <= r_cnt;
          if (r_cnt > r_max) r_max <= r_cnt;
          r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign launch_o  = r_launch;
  assign busy_o    = (r_state == ST_SETTLE) || (r_state == ST_FIRE) ||
                     (r_state == ST_WAIT)   || (r_state == ST_CAPTURE);
  assign done_o    = (r_state == ST_DONE);
  assign timeout_o = r_timeout;
  assign sum_o     = r_sum;
  assign min_o     = r_min;
  assign max_o     = r_max;

endmodule

`default_nettype wire
